// File: rtl/pingpong_mem.sv
// Ping-pong activation memory (A0/A1) plus weight bank B with 1-cycle registered reads.
// Reads use the current bank, result writes go to the other one, and swap exchanges their roles.
module pingpong_mem #(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int DEPTH    = 6400,
    parameter int IDX_W    = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                swap,
    input  logic                rd_en,
    input  logic [IDX_W-1:0]    data_idx,
    input  logic [IDX_W-1:0]    weight_idx,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    result_idx,
    input  logic [DATA_W-1:0]   result,
    input  logic                wload_en,
    input  logic [IDX_W-1:0]    wload_idx,
    input  logic [WEIGHT_W-1:0] wload_data,
    output logic [DATA_W-1:0]   data,
    output logic [WEIGHT_W-1:0] weight,
    output logic                rd_valid,
    output logic                bank,
    output logic [IDX_W-1:0]    wr_count,
    output logic                err_oob
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);

    logic [DATA_W-1:0]   mem_a0 [DEPTH];
    logic [DATA_W-1:0]   mem_a1 [DEPTH];
    logic [WEIGHT_W-1:0] mem_b  [DEPTH];

    logic                bank_q, bank_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   data_q;
    logic [WEIGHT_W-1:0] weight_q;
    logic                vld_q;

    logic d_ok, w_ok, r_ok, l_ok;
    logic wr_acc, ld_acc, oob;
    logic [AW-1:0] d_addr, w_addr, r_addr, l_addr;

    assign d_ok   = data_idx   < DEPTH_I;
    assign w_ok   = weight_idx < DEPTH_I;
    assign r_ok   = result_idx < DEPTH_I;
    assign l_ok   = wload_idx  < DEPTH_I;
    assign d_addr = data_idx[AW-1:0];
    assign w_addr = weight_idx[AW-1:0];
    assign r_addr = result_idx[AW-1:0];
    assign l_addr = wload_idx[AW-1:0];

    // Writes during reset are dropped so a reset cycle never disturbs memory contents.
    assign wr_acc = rstn && wr_en && r_ok;
    assign ld_acc = rstn && wload_en && l_ok;
    assign oob    = (rd_en && (!d_ok || !w_ok)) || (wr_en && !r_ok) || (wload_en && !l_ok);

    always_comb begin
        bank_d = bank_q;
        cnt_d  = cnt_q;
        err_d  = err_q | oob;
        if (swap) begin
            bank_d = ~bank_q;
            cnt_d  = '0;
        end else if (wr_acc && cnt_q != DEPTH_I) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            bank_q <= 1'b0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            bank_q <= bank_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && bank_q) mem_a0[r_addr] <= result;
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !bank_q) mem_a1[r_addr] <= result;
    end

    always_ff @(posedge clk) begin
        if (ld_acc) mem_b[l_addr] <= wload_data;
    end

    // Non-blocking RAM reads give read-before-write against same-edge writes.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            data_q   <= '0;
            weight_q <= '0;
            vld_q    <= 1'b0;
        end else begin
            vld_q <= rd_en;
            if (rd_en) begin
                data_q   <= !d_ok ? '0 : (bank_q ? mem_a1[d_addr] : mem_a0[d_addr]);
                weight_q <= w_ok ? mem_b[w_addr] : '0;
            end
        end
    end

    assign data     = data_q;
    assign weight   = weight_q;
    assign rd_valid = vld_q;
    assign bank     = bank_q;
    assign wr_count = cnt_q;
    assign err_oob  = err_q;
endmodule
